operand2_fetch: RTL and testbench

Operand-fetch stage directly upstream of the barrel shifter in the CPU execute path. It accepts one decoded data-processing instruction and reads Rn, Rm and Rs in sequence over a single synchronous register-file read port. It then presents the shifter-ready operand set (Immop, shift type, shift amount, value to shift) together with the Rn value and ALU control fields. Valid/ready handshake on both sides; one instruction in flight.

---
 rtl/operand2_fetch.sv | 306 ++++++++++++++++++++++++++++++
 tb/tb_operand2_fetch.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/operand2_fetch.sv
// Operand-fetch stage ahead of the barrel shifter: reads Rn/Rm/Rs over one synchronous RF port.
// Optional feature macro PC_BYPASS_EN: R15 operands are taken from in_Pc instead of the register file.

module operand2_fetch #(
  parameter int WORD_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 4
) (
  input  logic                      in_Clk,
  input  logic                      in_Rst_n,
  input  logic                      in_Valid,
  output logic                      out_Ready,
  input  logic [31:0]               in_Instr,
  input  logic                      in_Flush,
  output logic                      out_Rf_ren,
  output logic [REG_ADDR_WIDTH-1:0] out_Rf_addr,
  input  logic [WORD_WIDTH-1:0]     in_Rf_data,
  input  logic [WORD_WIDTH-1:0]     in_Pc,
  output logic                      out_Valid,
  input  logic                      in_Ready,
  output logic                      out_Immop,
  output logic [1:0]                out_Shift_type,
  output logic [7:0]                out_Shift_amt,
  output logic                      out_Shift_by_reg,
  output logic [WORD_WIDTH-1:0]     out_Val,
  output logic [WORD_WIDTH-1:0]     out_Rn_val,
  output logic [3:0]                out_Opcode,
  output logic                      out_S,
  output logic [REG_ADDR_WIDTH-1:0] out_Rd
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_OUT   = 2'd2
  } state_t;

  localparam logic [1:0] ROLE_RN = 2'd0;
  localparam logic [1:0] ROLE_RM = 2'd1;
  localparam logic [1:0] ROLE_RS = 2'd2;

  function automatic logic is_pc_bypass(input logic [3:0] addr);
`ifdef PC_BYPASS_EN
    return (addr == 4'hF);
`else
    return (addr == 4'hF) && 1'b0;
`endif
  endfunction

  state_t                    r_state;
  state_t                    w_next_state;
  logic [31:0]               r_instr;
  logic [REG_ADDR_WIDTH-1:0] r_list_addr [3];
  logic [REG_ADDR_WIDTH-1:0] w_list_addr [3];
  logic [1:0]                r_list_role [3];
  logic [1:0]                w_list_role [3];
  logic [1:0]                r_n;
  logic [1:0]                w_n;
  logic [1:0]                r_issue_cnt;
  logic [1:0]                r_cap_cnt;
  logic                      r_ren_d;
  logic [WORD_WIDTH-1:0]     r_rn;
  logic [WORD_WIDTH-1:0]     r_rm;
  logic [7:0]                r_rs;
  logic [WORD_WIDTH-1:0]     w_rn_init;
  logic [WORD_WIDTH-1:0]     w_rm_init;
  logic [7:0]                w_rs_init;
  logic [WORD_WIDTH-1:0]     w_rn_fin;
  logic [WORD_WIDTH-1:0]     w_rm_fin;
  logic [7:0]                w_rs_fin;
  logic                      w_use_rn;
  logic                      w_use_rm;
  logic                      w_use_rs;
  logic                      w_cap;
  logic [1:0]                w_cap_role;
  logic                      w_all_cap;
  logic [WORD_WIDTH-1:0]     w_fmt_val;
  logic [1:0]                w_fmt_type;
  logic [7:0]                w_fmt_amt;
  logic                      w_fmt_by_reg;

  logic                      r_rf_ren;
  logic [REG_ADDR_WIDTH-1:0] r_rf_addr;
  logic                      r_valid;
  logic                      r_immop;
  logic [1:0]                r_shift_type;
  logic [7:0]                r_shift_amt;
  logic                      r_shift_by_reg;
  logic [WORD_WIDTH-1:0]     r_val;
  logic [WORD_WIDTH-1:0]     r_rn_val;
  logic [3:0]                r_opcode;
  logic                      r_s;
  logic [REG_ADDR_WIDTH-1:0] r_rd;

  logic                      w_unused_bits;
  assign w_unused_bits = ^{r_instr[31:26], r_instr[19:16], r_instr[3:0]};

  // Ordered read list built from the incoming instruction (used on accept)
  always_comb begin
    w_list_addr = '{default: '0};
    w_list_role = '{default: ROLE_RN};
    w_n         = 2'd0;
    w_rn_init   = '0;
    w_rm_init   = '0;
    w_rs_init   = 8'd0;
    w_use_rn    = (in_Instr[24:21] != 4'b1101) && (in_Instr[24:21] != 4'b1111);
    w_use_rm    = ~in_Instr[25];
    w_use_rs    = ~in_Instr[25] & in_Instr[4];
    if (w_use_rn && is_pc_bypass(in_Instr[19:16])) begin
      w_rn_init = in_Pc;
    end else if (w_use_rn) begin
      w_list_addr[w_n] = REG_ADDR_WIDTH'(in_Instr[19:16]);
      w_list_role[w_n] = ROLE_RN;
      w_n              = w_n + 2'd1;
    end else begin
      w_rn_init = '0;
    end
    if (w_use_rm && is_pc_bypass(in_Instr[3:0])) begin
      w_rm_init = in_Pc;
    end else if (w_use_rm) begin
      w_list_addr[w_n] = REG_ADDR_WIDTH'(in_Instr[3:0]);
      w_list_role[w_n] = ROLE_RM;
      w_n              = w_n + 2'd1;
    end else begin
      w_rm_init = '0;
    end
    if (w_use_rs && is_pc_bypass(in_Instr[11:8])) begin
      w_rs_init = in_Pc[7:0];
    end else if (w_use_rs) begin
      w_list_addr[w_n] = REG_ADDR_WIDTH'(in_Instr[11:8]);
      w_list_role[w_n] = ROLE_RS;
      w_n              = w_n + 2'd1;
    end else begin
      w_rs_init = 8'd0;
    end
  end

  // Read-data capture; the final operand set overlays data arriving this cycle
  always_comb begin
    w_cap      = (r_state == ST_FETCH) && r_ren_d;
    w_cap_role = r_list_role[r_cap_cnt];
    w_rn_fin   = r_rn;
    w_rm_fin   = r_rm;
    w_rs_fin   = r_rs;
    if (w_cap) begin
      case (w_cap_role)
        ROLE_RN: w_rn_fin = in_Rf_data;
        ROLE_RM: w_rm_fin = in_Rf_data;
        ROLE_RS: w_rs_fin = in_Rf_data[7:0];
        default: w_rn_fin = r_rn;
      endcase
    end else begin
      w_rn_fin = r_rn;
    end
    w_all_cap = (r_state == ST_FETCH) && ((r_cap_cnt + {1'b0, w_cap}) == r_n);
  end

  // Shifter operand formation from the latched instruction
  always_comb begin
    w_fmt_val    = w_rm_fin;
    w_fmt_type   = r_instr[6:5];
    w_fmt_amt    = {3'b000, r_instr[11:7]};
    w_fmt_by_reg = 1'b0;
    if (r_instr[25]) begin
      w_fmt_val    = WORD_WIDTH'(r_instr[7:0]);
      w_fmt_type   = 2'b11;
      w_fmt_amt    = {3'b000, r_instr[11:8], 1'b0};
      w_fmt_by_reg = 1'b0;
    end else if (r_instr[4]) begin
      w_fmt_amt    = w_rs_fin;
      w_fmt_by_reg = 1'b1;
    end else begin
      w_fmt_by_reg = 1'b0;
    end
  end

  // Next-state logic; flush overrides accept and handshake
  always_comb begin
    w_next_state = r_state;
    if (in_Flush) begin
      w_next_state = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:  w_next_state = in_Valid  ? ST_FETCH : ST_IDLE;
        ST_FETCH: w_next_state = w_all_cap ? ST_OUT   : ST_FETCH;
        ST_OUT:   w_next_state = in_Ready  ? ST_IDLE  : ST_OUT;
        default:  w_next_state = ST_IDLE;
      endcase
    end
  end

  // State register
  always_ff @(posedge in_Clk or negedge in_Rst_n) begin
    if (!in_Rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Read sequencing, operand capture and registered outputs
  always_ff @(posedge in_Clk or negedge in_Rst_n) begin
    if (!in_Rst_n) begin
      r_instr        <= 32'd0;
      r_list_addr    <= '{default: '0};
      r_list_role    <= '{default: ROLE_RN};
      r_n            <= 2'd0;
      r_issue_cnt    <= 2'd0;
      r_cap_cnt      <= 2'd0;
      r_ren_d        <= 1'b0;
      r_rn           <= '0;
      r_rm           <= '0;
      r_rs           <= 8'd0;
      r_rf_ren       <= 1'b0;
      r_rf_addr      <= '0;
      r_valid        <= 1'b0;
      r_immop        <= 1'b0;
      r_shift_type   <= 2'd0;
      r_shift_amt    <= 8'd0;
      r_shift_by_reg <= 1'b0;
      r_val          <= '0;
      r_rn_val       <= '0;
      r_opcode       <= 4'd0;
      r_s            <= 1'b0;
      r_rd           <= '0;
    end else if (in_Flush) begin
      r_rf_ren <= 1'b0;
      r_ren_d  <= 1'b0;
      r_valid  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_ren_d <= 1'b0;
          if (in_Valid) begin
            r_instr     <= in_Instr;
            r_list_addr <= w_list_addr;
            r_list_role <= w_list_role;
            r_n         <= w_n;
            r_cap_cnt   <= 2'd0;
            r_rn        <= w_rn_init;
            r_rm        <= w_rm_init;
            r_rs        <= w_rs_init;
            r_rf_ren    <= (w_n != 2'd0);
            r_issue_cnt <= (w_n != 2'd0) ? 2'd1 : 2'd0;
            if (w_n != 2'd0) begin
              r_rf_addr <= w_list_addr[0];
            end
          end
        end
        ST_FETCH: begin
          r_ren_d <= r_rf_ren;
          if (r_issue_cnt != r_n) begin
            r_rf_ren    <= 1'b1;
            r_rf_addr   <= r_list_addr[r_issue_cnt];
            r_issue_cnt <= r_issue_cnt + 2'd1;
          end else begin
            r_rf_ren <= 1'b0;
          end
          if (w_cap) begin
            r_rn      <= w_rn_fin;
            r_rm      <= w_rm_fin;
            r_rs      <= w_rs_fin;
            r_cap_cnt <= r_cap_cnt + 2'd1;
          end
          if (w_all_cap) begin
            r_valid        <= 1'b1;
            r_immop        <= r_instr[25];
            r_shift_type   <= w_fmt_type;
            r_shift_amt    <= w_fmt_amt;
            r_shift_by_reg <= w_fmt_by_reg;
            r_val          <= w_fmt_val;
            r_rn_val       <= w_rn_fin;
            r_opcode       <= r_instr[24:21];
            r_s            <= r_instr[20];
            r_rd           <= REG_ADDR_WIDTH'(r_instr[15:12]);
          end
        end
        ST_OUT: begin
          r_ren_d <= 1'b0;
          if (in_Ready) begin
            r_valid <= 1'b0;
          end
        end
        default: begin
          r_rf_ren <= 1'b0;
          r_ren_d  <= 1'b0;
          r_valid  <= 1'b0;
        end
      endcase
    end
  end

  assign out_Ready        = (r_state == ST_IDLE);
  assign out_Rf_ren       = r_rf_ren;
  assign out_Rf_addr      = r_rf_addr;
  assign out_Valid        = r_valid;
  assign out_Immop        = r_immop;
  assign out_Shift_type   = r_shift_type;
  assign out_Shift_amt    = r_shift_amt;
  assign out_Shift_by_reg = r_shift_by_reg;
  assign out_Val          = r_val;
  assign out_Rn_val       = r_rn_val;
  assign out_Opcode       = r_opcode;
  assign out_S            = r_s;
  assign out_Rd           = r_rd;

endmodule

// File: tb/tb_operand2_fetch.sv
// Bench for operand2_fetch: directed plan cases plus randomized instructions against a behavioural model.
module tb_operand2_fetch;

`ifdef PC_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk, rst_n, valid_in, ready_out, flush, rf_ren, valid_out, ready_in;
  logic [31:0] instr, pc, rf_data, val, rn_val;
  logic [3:0]  rf_addr, opcode, rd;
  logic [1:0]  stype;
  logic [7:0]  amt;
  logic        immop, by_reg, s_bit;

  logic [31:0] rf [16];
  int          tests = 0;
  int          fails = 0;

  int unsigned exp_q[$];
  logic [31:0] e_val, e_rn, e_amt, e_type, e_imm, e_by, e_opc, e_s, e_rd;

  operand2_fetch dut (
    .in_Clk(clk), .in_Rst_n(rst_n), .in_Valid(valid_in), .out_Ready(ready_out),
    .in_Instr(instr), .in_Flush(flush), .out_Rf_ren(rf_ren), .out_Rf_addr(rf_addr),
    .in_Rf_data(rf_data), .in_Pc(pc), .out_Valid(valid_out), .in_Ready(ready_in),
    .out_Immop(immop), .out_Shift_type(stype), .out_Shift_amt(amt),
    .out_Shift_by_reg(by_reg), .out_Val(val), .out_Rn_val(rn_val),
    .out_Opcode(opcode), .out_S(s_bit), .out_Rd(rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // synchronous-read register file
  always @(posedge clk) if (rf_ren) rf_data <= rf[rf_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic take(input logic [3:0] r, input logic [31:0] p, output logic [31:0] v);
    if (BYP && r == 4'd15) v = p;
    else begin
      exp_q.push_back(32'(r));
      v = rf[r];
    end
  endtask

  task automatic model(input logic [31:0] ins, input logic [31:0] p);
    logic [31:0] rnv, rmv, rsv;
    exp_q.delete();
    rnv = 0; rmv = 0; rsv = 0;
    if (!(ins[24:21] == 4'd13 || ins[24:21] == 4'd15)) take(ins[19:16], p, rnv);
    if (!ins[25]) take(ins[3:0], p, rmv);
    if (!ins[25] && ins[4]) take(ins[11:8], p, rsv);
    e_imm = 32'(ins[25]);
    e_rn  = rnv;
    e_opc = 32'(ins[24:21]);
    e_s   = 32'(ins[20]);
    e_rd  = 32'(ins[15:12]);
    if (ins[25]) begin
      e_val = 32'(ins[7:0]); e_type = 3; e_amt = 32'(ins[11:8]) * 2; e_by = 0;
    end else begin
      e_val = rmv; e_type = 32'(ins[6:5]);
      e_amt = ins[4] ? rsv % 256 : 32'(ins[11:7]);
      e_by  = 32'(ins[4]);
    end
  endtask

  task automatic check_outputs(input string pfx);
    chk({pfx, "_immop"}, 32'(immop), e_imm);
    chk({pfx, "_type"},  32'(stype), e_type);
    chk({pfx, "_amt"},   32'(amt), e_amt);
    chk({pfx, "_byreg"}, 32'(by_reg), e_by);
    chk({pfx, "_val"},   val, e_val);
    chk({pfx, "_rnval"}, rn_val, e_rn);
    chk({pfx, "_opcode"}, 32'(opcode), e_opc);
    chk({pfx, "_s"},     32'(s_bit), e_s);
    chk({pfx, "_rd"},    32'(rd), e_rd);
  endtask

  task automatic run_txn(input logic [31:0] ins, input int stall, input bit hold, input logic [31:0] p);
    int k;
    model(ins, p);
    @(negedge clk);
    chk("ready_idle", 32'(ready_out), 1);
    valid_in = 1'b1; instr = ins; pc = p; ready_in = (stall == 0);
    @(negedge clk);
    if (hold) instr = $urandom; else valid_in = 1'b0;
    pc = $urandom;
    k = 0;
    while (!valid_out && k <= 8) begin
      chk("ren", 32'(rf_ren), 32'(k < exp_q.size()));
      if (rf_ren && k < exp_q.size()) chk("addr", 32'(rf_addr), exp_q[k]);
      if (exp_q.size() > 0) chk("busy", 32'(ready_out), 0);
      k++;
      @(negedge clk);
    end
    chk("latency", 32'(k), 32'(exp_q.size() + 1));
    check_outputs("out");
    for (int s = 1; s < stall; s++) begin
      @(negedge clk);
      chk("hold_valid", 32'(valid_out), 1);
      chk("hold_ready", 32'(ready_out), 0);
      chk("hold_ren", 32'(rf_ren), 0);
      chk("hold_val", val, e_val);
      chk("hold_amt", 32'(amt), e_amt);
    end
    ready_in = 1'b1;
    @(negedge clk);
    valid_in = 1'b0;
    chk("post_valid", 32'(valid_out), 0);
    chk("post_ready", 32'(ready_out), 1);
  endtask

  initial begin
    logic [31:0] ins;
    rst_n = 1'b0; valid_in = 1'b0; ready_in = 1'b0; flush = 1'b0; instr = 0; pc = 0;
    for (int i = 0; i < 16; i++) rf[i] = $urandom;
    @(negedge clk);
    chk("rst_ready", 32'(ready_out), 1);
    chk("rst_valid", 32'(valid_out), 0);
    chk("rst_ren", 32'(rf_ren), 0);
    chk("rst_addr", 32'(rf_addr), 0);
    chk("rst_val", val, 0);
    chk("rst_amt", 32'(amt), 0);
    rst_n = 1'b1;

    rf[2] = 32'h1000;
    run_txn(32'hE2821EFF, 0, 1'b0, 32'h0);
    rf[3] = 32'hA5;
    run_txn(32'hE1A00203, 0, 1'b0, 32'h0);
    rf[1] = 32'd7; rf[2] = 32'h8000_0000; rf[3] = 32'h120;
    run_txn(32'hE0810332, 0, 1'b0, 32'h0);
    run_txn(32'hE0810332, 5, 1'b1, 32'h0);

    // flush sampled at E2 while reading Rm
    @(negedge clk);
    valid_in = 1'b1; instr = 32'hE0810332; ready_in = 1'b1;
    @(negedge clk);
    valid_in = 1'b0;
    chk("fl_ren0", 32'(rf_ren), 1);
    @(negedge clk);
    chk("fl_addr1", 32'(rf_addr), 2);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("fl_ren", 32'(rf_ren), 0);
    chk("fl_ready", 32'(ready_out), 1);
    for (int i = 0; i < 4; i++) begin
      chk("fl_novalid", 32'(valid_out), 0);
      @(negedge clk);
    end
    run_txn(32'hE0810332, 0, 1'b0, 32'h0);

    // asynchronous reset in the middle of FETCH
    @(negedge clk);
    valid_in = 1'b1; instr = 32'hE0810332;
    @(negedge clk);
    valid_in = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ready", 32'(ready_out), 1);
    chk("arst_valid", 32'(valid_out), 0);
    chk("arst_ren", 32'(rf_ren), 0);
    chk("arst_addr", 32'(rf_addr), 0);
    chk("arst_val", val, 0);
    chk("arst_rnval", rn_val, 0);
    chk("arst_opcode", 32'(opcode), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // ADD r0,pc,#4: bypassed from in_Pc when enabled, otherwise read as R15
    rf[15] = 32'hCAFE_0010;
    run_txn(32'hE28F0004, 0, 1'b0, 32'h108);

    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < 16; i++) rf[i] = $urandom;
      ins = $urandom;
      ins[31:26] = 6'b111000;
      run_txn(ins, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
